// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the EX stage.
// Executes mult/multu/div/divu with fixed latencies and owns HI/LO.
// mthi/mtlo write HI/LO in one cycle, and mfhi/mflo read them combinationally.
//
// Ports:
//   clk    - pipeline clock; all state updates on the rising edge
//   reset  - synchronous, active-high; clears busy, HI, LO and the counter
//   start  - qualifies md_op for the instruction currently in EX
//   md_op  - 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
//   A, B   - forwarded rs / rt operands
//   busy   - registered; high while a mult/div is in flight
//   HI, LO - architectural HI/LO registers
//   md_out - combinational: HI for mfhi, LO for mflo, otherwise 0
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  // Result is computed when the operation is accepted and held until the
  // counter expires; res_wr_q is cleared for a divide by zero so that the
  // full busy period still runs but HI/LO are left untouched.
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;

  // Multiplies: sign-extending to 64 bits makes the low 64 bits of the
  // product equal to the signed 64-bit result.
  logic [63:0] mul_s_s;
  logic [63:0] mul_u_s;
  assign mul_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign mul_u_s = {32'd0, A} * {32'd0, B};

  // Signed divide by magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
  // as magnitude 0x80000000 whose negation is itself, remainder 0.
  logic        b_zero_s;
  logic [31:0] a_mag_s, b_mag_s, b_mag_safe_s, b_safe_s;
  logic [31:0] sq_mag_s, sr_mag_s, sdiv_q_s, sdiv_r_s;
  logic [31:0] udiv_q_s, udiv_r_s;
  assign b_zero_s     = (B == 32'd0);
  assign a_mag_s      = A[31] ? (32'd0 - A) : A;
  assign b_mag_s      = B[31] ? (32'd0 - B) : B;
  assign b_mag_safe_s = b_zero_s ? 32'd1 : b_mag_s;
  assign b_safe_s     = b_zero_s ? 32'd1 : B;
  assign sq_mag_s     = a_mag_s / b_mag_safe_s;
  assign sr_mag_s     = a_mag_s % b_mag_safe_s;
  assign sdiv_q_s     = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sdiv_r_s     = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  assign udiv_q_s     = A / b_safe_s;
  assign udiv_r_s     = A % b_safe_s;

  // Next-state logic: accept operations in IDLE, count down and commit in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              res_hi_d = mul_s_s[63:32];
              res_lo_d = mul_s_s[31:0];
              res_wr_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = S_RUN;
            end
            OP_MULTU: begin
              res_hi_d = mul_u_s[63:32];
              res_lo_d = mul_u_s[31:0];
              res_wr_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = S_RUN;
            end
            OP_DIV: begin
              res_hi_d = sdiv_r_s;
              res_lo_d = sdiv_q_s;
              res_wr_d = ~b_zero_s;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = S_RUN;
            end
            OP_DIVU: begin
              res_hi_d = udiv_r_s;
              res_lo_d = udiv_q_s;
              res_wr_d = ~b_zero_s;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // start is ignored here; the hazard controller should never issue it.
        if (cnt_q == CNT_W'(1)) begin
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset; reset in RUN aborts without commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // mfhi/mflo read path: zero latency, no register.
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed steps, expected HI/LO pushed to a
// scoreboard queue at issue and popped when busy drops.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, md_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] sb_q[$];

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle and update the reference model.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      4'd1: begin
        q = sa * sb;
        m_hi = q[63:32]; m_lo = q[31:0];
        sb_q.push_back({m_hi, m_lo});
      end
      4'd2: begin
        up = ua * ub;
        m_hi = up[63:32]; m_lo = up[31:0];
        sb_q.push_back({m_hi, m_lo});
      end
      4'd3: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        sb_q.push_back({m_hi, m_lo});
      end
      4'd4: begin
        if (b != 32'd0) begin
          m_lo = a / b; m_hi = a % b;
        end
        sb_q.push_back({m_hi, m_lo});
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  // Count busy cycles (starting from 'already'), then pop and compare result.
  task automatic wait_done(input string tag, input int exp_n, input int already);
    int n;
    logic [63:0] e;
    n = already;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = {m_hi, m_lo};
    end
    check({tag, "_hi"}, HI, e[63:32]);
    check({tag, "_lo"}, LO, e[31:0]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_md_out", md_out, 32'd0);

    // mult -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_c1", {31'd0, busy}, 32'd1);
    wait_done("mult", MC, 0);
    check("mult_const_hi", HI, 32'hFFFF_FFFF);
    check("mult_const_lo", LO, 32'hFFFF_FFFA);
    md_op = 4'd7; #1;
    check("mfhi", md_out, m_hi);
    md_op = 4'd8; #1;
    check("mflo", md_out, m_lo);
    md_op = 4'd0; #1;
    check("md_out_none", md_out, 32'd0);

    // multu max * max, back-to-back in first non-busy cycle
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", MC, 0);
    check("multu_const_hi", HI, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", DC, 0);
    check("div_const_lo", LO, 32'hFFFF_FFFD);

    // mthi/mtlo then divu by zero
    issue(4'd5, 32'h11, 32'd0);
    check("mthi_hi", HI, 32'h11);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 4'd7; #1;
    check("mfhi_after_mthi", md_out, 32'h11);
    md_op = 4'd0;
    issue(4'd6, 32'h22, 32'd0);
    check("mtlo_lo", LO, 32'h22);
    issue(4'd9, 32'h99, 32'h99);
    check("op9_hi", HI, 32'h11);
    check("op9_lo", LO, 32'h22);
    check("op9_busy", {31'd0, busy}, 32'd0);
    issue(4'd4, 32'd5, 32'd0);
    wait_done("divu0", DC, 0);
    check("divu0_const_hi", HI, 32'h11);
    check("divu0_const_lo", LO, 32'h22);

    // signed overflow
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DC, 0);
    check("div_ovf_const_lo", LO, 32'h8000_0000);

    // unsigned divide, ordinary values
    issue(4'd4, 32'd100, 32'd7);
    wait_done("divu", DC, 0);

    // protocol-illegal start while busy must be ignored
    issue(4'd1, 32'd7, 32'hFFFF_FFFA);
    step();
    $display("note: issuing protocol-illegal start while busy; DUT must ignore it");
    start = 1'b1; md_op = 4'd3; A = 32'd100; B = 32'd3;
    step();
    start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0;
    wait_done("ignored_start", MC, 2);

    // reset in busy cycle 4 of a divide
    issue(4'd3, 32'd100, 32'd7);
    step();
    step();
    step();
    check("abort_busy_c4", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    sb_q.delete();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (DC + 2) step();
    check("abort_nocommit_hi", HI, 32'd0);
    check("abort_nocommit_lo", LO, 32'd0);
    check("abort_nocommit_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
